// File: rtl/fft_ram_reader.sv
// Read-side sequencer for the fft_ram spectrum buffer: walks the RAM read port
// and streams bins on a valid/ready interface through a 2-entry skid buffer.
module fft_ram_reader #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int FRAME_LEN  = 2048
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  start,
   input  logic                  half_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH-1:0] m_index,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LEN_FULL = CW'(FRAME_LEN);
   localparam logic [CW-1:0] LEN_HALF = CW'(FRAME_LEN / 2);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         len;
   logic [CW-1:0]         issue_cnt;
   logic [CW-1:0]         cnt_p1;
   logic                  in_flight;
   logic [ADDR_WIDTH-1:0] flight_idx;
   logic [1:0]            count;
   logic [DATA_WIDTH-1:0] d0, d1;
   logic [ADDR_WIDTH-1:0] i0, i1;
   logic                  pop;
   logic                  issue;
   logic                  last_issue;
   logic [2:0]            occ;

   always_comb begin
      pop        = (count != 2'd0) && m_ready;
      // occupancy after this cycle's pop, counting the word still in the RAM pipe
      occ        = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
      issue      = (state == S_READ) && (occ < 3'd2);
      last_issue = issue && (issue_cnt == len - CW'(1));
      cnt_p1     = issue_cnt + CW'(1);

      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_READ;
         S_READ:  if (last_issue) state_nx = S_DRAIN;
         S_DRAIN: if (!in_flight && (count == 2'd0 || (count == 2'd1 && pop)))
                     state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      m_valid = (count != 2'd0);
      m_data  = d0;
      m_index = i0;
      m_last  = m_valid && ({1'b0, i0} == len - CW'(1));
      busy    = (state != S_IDLE);
      done    = (state == S_DONE);
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state       <= S_IDLE;
         len         <= '0;
         issue_cnt   <= '0;
         ram_rd_addr <= '0;
         in_flight   <= 1'b0;
         flight_idx  <= '0;
      end else begin
         state     <= state_nx;
         in_flight <= issue;
         if (state == S_IDLE && start) begin
            len         <= half_en ? LEN_HALF : LEN_FULL;
            issue_cnt   <= '0;
            ram_rd_addr <= '0;
         end else if (issue) begin
            issue_cnt  <= cnt_p1;
            flight_idx <= issue_cnt[ADDR_WIDTH-1:0];
            // address register pre-loads the next address; held after the final one
            if (!last_issue) ram_rd_addr <= cnt_p1[ADDR_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         count <= '0;
         d0    <= '0;
         d1    <= '0;
         i0    <= '0;
         i1    <= '0;
      end else begin
         case ({in_flight, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  d0 <= ram_rd_data;
                  i0 <= flight_idx;
               end else begin
                  d1 <= ram_rd_data;
                  i1 <= flight_idx;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               d0    <= d1;
               i0    <= i1;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  d0 <= ram_rd_data;
                  i0 <= flight_idx;
               end else begin
                  d0 <= d1;
                  i0 <= i1;
                  d1 <= ram_rd_data;
                  i1 <= flight_idx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_ram_reader.sv
// Directed bench for fft_ram_reader with a 1-cycle-latency RAM model.
module tb_fft_ram_reader;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int FL = 2048;

   logic          clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic          start = 1'b0;
   logic          half_en = 1'b0;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] m_data;
   logic [AW-1:0] m_index;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic          m_last;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [FL];

   int checks = 0;
   int errors = 0;

   int n_xfer, first_valid, done_cyc, done_cnt, last_cnt, last_idx, bad_words;
   int max_addr, stall_max_addr, unstable, gaps, busy_first, busy_last, timeout;
   logic          snap_valid, snap_busy, snap_last, snap_done;
   logic [AW-1:0] snap_addr;

   fft_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
      .rd_clk(clk), .rd_rst(rd_rst), .start(start), .half_en(half_en),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
      .m_last(m_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

   // mode 0: ready always; 1: random ready; 2: ready low in cycles 3..22
   task automatic run_frame(input logic half, input int mode, input int restart_cyc,
                            input int rst_cyc);
      int            cyc, flen;
      logic          pv, pr, pl, fin;
      logic [DW-1:0] pd;
      logic [AW-1:0] pi;
      flen = half ? FL / 2 : FL;
      n_xfer = 0; first_valid = -1; done_cyc = -1; done_cnt = 0; last_cnt = 0;
      last_idx = -1; bad_words = 0; max_addr = 0; stall_max_addr = 0; unstable = 0;
      gaps = 0; busy_first = -1; busy_last = -1; timeout = 0;
      pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pi = '0; fin = 1'b0;
      @(negedge clk);
      cyc = 0; start = 1'b1; half_en = half; m_ready = 1'b1;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         start  = (cyc == restart_cyc);
         rd_rst = (cyc == rst_cyc);
         case (mode)
            1:       m_ready = 1'($urandom_range(0, 1));
            2:       m_ready = !(cyc >= 3 && cyc <= 22);
            default: m_ready = 1'b1;
         endcase
         if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
            snap_valid = m_valid; snap_busy = busy; snap_addr = ram_rd_addr;
            snap_last = m_last; snap_done = done;
            fin = 1'b1;
         end else begin
            if (pv && !pr && (m_data !== pd || m_index !== pi || m_last !== pl)) unstable++;
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (busy) begin
               if (busy_first < 0) busy_first = cyc;
               busy_last = cyc;
            end
            if (int'(ram_rd_addr) > max_addr) max_addr = int'(ram_rd_addr);
            if (mode == 2 && cyc <= 22 && int'(ram_rd_addr) > stall_max_addr)
               stall_max_addr = int'(ram_rd_addr);
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (m_valid && m_ready) begin
               if (int'(m_index) != n_xfer || m_data !== (32'hFFFF_FFFF - 32'(n_xfer)))
                  bad_words++;
               if (m_last) begin
                  last_cnt++;
                  last_idx = int'(m_index);
               end
               n_xfer++;
            end else if (m_ready && !m_valid && first_valid >= 0 && n_xfer < flen) begin
               gaps++;
            end
            pv = m_valid; pr = m_ready; pd = m_data; pi = m_index; pl = m_last;
            if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1'b1;
            if (cyc >= 12000) begin
               timeout = 1;
               fin = 1'b1;
            end
         end
      end
      start = 1'b0; rd_rst = 1'b0; m_ready = 1'b1; half_en = 1'b0;
   endtask

   task automatic test_reset();
      rd_rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", m_last); end
      checks++; if (ram_rd_addr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_rd_addr); end
      checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", m_data); end
      checks++; if (m_index !== '0) begin errors++; $display("FAIL reset_index got %0d want 0", m_index); end
      rd_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      run_frame(1'b0, 0, -1, -1);
      checks++; if (timeout != 0) begin errors++; $display("FAIL full_timeout got %0d want 0", timeout); end
      checks++; if (n_xfer != 2048) begin errors++; $display("FAIL full_count got %0d want 2048", n_xfer); end
      checks++; if (bad_words != 0) begin errors++; $display("FAIL full_words bad %0d want 0", bad_words); end
      checks++; if (first_valid != 3) begin errors++; $display("FAIL full_first_valid got %0d want 3", first_valid); end
      checks++; if (done_cyc != 2051) begin errors++; $display("FAIL full_done_cyc got %0d want 2051", done_cyc); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt got %0d want 1", done_cnt); end
      checks++; if (last_cnt != 1 || last_idx != 2047) begin errors++; $display("FAIL full_last cnt %0d idx %0d want 1/2047", last_cnt, last_idx); end
      checks++; if (busy_first != 1 || busy_last != 2051) begin errors++; $display("FAIL full_busy %0d..%0d want 1..2051", busy_first, busy_last); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL full_bubbles got %0d want 0", gaps); end
   endtask

   task automatic test_half_frame();
      run_frame(1'b1, 0, -1, -1);
      checks++; if (n_xfer != 1024) begin errors++; $display("FAIL half_count got %0d want 1024", n_xfer); end
      checks++; if (bad_words != 0) begin errors++; $display("FAIL half_words bad %0d want 0", bad_words); end
      checks++; if (last_cnt != 1 || last_idx != 1023) begin errors++; $display("FAIL half_last cnt %0d idx %0d want 1/1023", last_cnt, last_idx); end
      checks++; if (max_addr > 1023) begin errors++; $display("FAIL half_max_addr got %0d want <=1023", max_addr); end
      checks++; if (done_cyc != 1027) begin errors++; $display("FAIL half_done_cyc got %0d want 1027", done_cyc); end
   endtask

   task automatic test_random_ready();
      run_frame(1'b0, 1, -1, -1);
      checks++; if (timeout != 0) begin errors++; $display("FAIL rand_timeout got %0d want 0", timeout); end
      checks++; if (n_xfer != 2048) begin errors++; $display("FAIL rand_count got %0d want 2048", n_xfer); end
      checks++; if (bad_words != 0) begin errors++; $display("FAIL rand_words bad %0d want 0", bad_words); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL rand_stable violations %0d want 0", unstable); end
      checks++; if (last_cnt != 1 || last_idx != 2047) begin errors++; $display("FAIL rand_last cnt %0d idx %0d want 1/2047", last_cnt, last_idx); end
   endtask

   task automatic test_stall();
      run_frame(1'b0, 2, -1, -1);
      checks++; if (stall_max_addr > 2) begin errors++; $display("FAIL stall_issue addr %0d want <=2", stall_max_addr); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable violations %0d want 0", unstable); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL stall_bubbles got %0d want 0", gaps); end
      checks++; if (n_xfer != 2048 || bad_words != 0) begin errors++; $display("FAIL stall_words n %0d bad %0d want 2048/0", n_xfer, bad_words); end
      checks++; if (done_cyc != 2071) begin errors++; $display("FAIL stall_done_cyc got %0d want 2071", done_cyc); end
   endtask

   task automatic test_restart_ignored();
      run_frame(1'b1, 0, 100, -1);
      checks++; if (n_xfer != 1024) begin errors++; $display("FAIL restart_count got %0d want 1024", n_xfer); end
      checks++; if (done_cyc != 1027 || done_cnt != 1) begin errors++; $display("FAIL restart_done cyc %0d cnt %0d want 1027/1", done_cyc, done_cnt); end
      checks++; if (last_idx != 1023 || bad_words != 0) begin errors++; $display("FAIL restart_last idx %0d bad %0d want 1023/0", last_idx, bad_words); end
   endtask

   task automatic test_mid_reset();
      run_frame(1'b0, 0, -1, 500);
      checks++; if (n_xfer != 498) begin errors++; $display("FAIL midrst_pre_count got %0d want 498", n_xfer); end
      checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", snap_valid); end
      checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", snap_busy); end
      checks++; if (snap_addr !== '0) begin errors++; $display("FAIL midrst_addr got %0d want 0", snap_addr); end
      checks++; if (snap_last !== 1'b0 || snap_done !== 1'b0) begin errors++; $display("FAIL midrst_last_done got %b/%b want 0/0", snap_last, snap_done); end
      run_frame(1'b0, 0, -1, -1);
      checks++; if (n_xfer != 2048 || bad_words != 0) begin errors++; $display("FAIL midrst_frame n %0d bad %0d want 2048/0", n_xfer, bad_words); end
      checks++; if (first_valid != 3 || done_cyc != 2051) begin errors++; $display("FAIL midrst_timing first %0d done %0d want 3/2051", first_valid, done_cyc); end
   endtask

   initial begin
      for (int i = 0; i < FL; i++) mem[i] = 32'hFFFF_FFFF - 32'(i);
      test_reset();
      test_full_frame();
      test_half_frame();
      test_random_ready();
      test_stall();
      test_restart_ignored();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
